rcv_ctrl: RTL and testbench
===========================

# rcv_ctrl

Receive-side sequencer for the 8N1 serial receiver. It watches the line for a start bit and times each bit period. It pulses `shift_enable` at every data-bit midpoint into the receive shift register and checks the stop bit. On a good frame it strobes `load_buffer` into the receive data buffer and maintains the `data_ready`, overrun and framing-error status flags seen by the host side.

## Interface
- `CLKS_PER_BIT`, 10, clock cycles per serial bit period; must be ≥ 4.
- `NUM_BITS`, 8, data bits per frame; must match the shift register width.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `serial_in`  in  1  receive line; idle is high.
- `data_read`  in  1  host has consumed the buffer; single-cycle pulse.
- `shift_enable`  out  1  one-cycle pulse at each data-bit midpoint; drives the shift register.
- `load_buffer`  out  1  one-cycle pulse that copies the shift register into the data buffer.
- `data_ready`  out  1  buffer holds an unread byte.
- `overrun_error`  out  1  a byte was loaded while `data_ready` was already set.
- `framing_error`  out  1  the last frame's stop bit sampled low.
- `rx_busy`  out  1  high whenever the state is not IDLE.

## Operation
- Internal registers:
  - `prev_in`: last sampled line value, reset value 1.
  - `timer`: width clog2(CLKS_PER_BIT).
  - `bit_cnt`: width clog2(NUM_BITS+1).
  - `state`.
- `HALF` = CLKS_PER_BIT/2, rounded down by integer division.
- State machine:
  - IDLE: when `prev_in`=1 and `serial_in`=0, go to START_CHK and set `timer`=0.
  - START_CHK: `timer` increments each cycle. In the cycle where `timer`=HALF−1, sample `serial_in`:
    - 0: go to RECV with `timer`=0 and `bit_cnt`=0, and clear `framing_error`.
    - 1: false start; return to IDLE with no flag change.
  - RECV: `timer` counts 0..CLKS_PER_BIT−1 and wraps to 0. In the cycle where `timer`=CLKS_PER_BIT−1, `shift_enable`=1 and `bit_cnt` increments. When that pulse takes `bit_cnt` to NUM_BITS, go to STOP_CHK with `timer`=0.
  - STOP_CHK: in the cycle where `timer`=CLKS_PER_BIT−1, sample `serial_in`:
    - 1: go to LOAD.
    - 0: set `framing_error` and go to IDLE with no load and no `data_ready` change.
  - LOAD: `load_buffer`=1 for exactly this one cycle, then go to IDLE.
- `shift_enable`, `load_buffer` and `rx_busy` are combinational decodes of `state` and `timer`. The three flags are registered.
- `data_ready` next value:
  - Set on LOAD.
  - Cleared by `data_read`.
  - LOAD and `data_read` in the same cycle: stays 1, no overrun.
- `overrun_error`:
  - Set on LOAD when `data_ready`=1 and `data_read`=0 in that cycle.
  - Cleared by `data_read`. If LOAD and `data_read` coincide, no overrun is raised and an existing one clears.
  - The overwritten byte is lost; the buffer takes the newer byte.
- A line stuck low after a framing error does not retrigger. A start needs a fresh 1→0 edge.
- `data_read` while `data_ready`=0 has no effect.

## Timing
- Reset, applied in any state mid-frame: returns to IDLE in one cycle with all outputs 0, `prev_in`=1, `timer`=0, `bit_cnt`=0. A partial frame is discarded.
- Edge seen in cycle E puts the block in START_CHK at E+1. The start sample is at E+HALF. The first `shift_enable` is at E+HALF+CLKS_PER_BIT.
- Data-bit pulse k (k=0..NUM_BITS−1) is at E+HALF+(k+1)·CLKS_PER_BIT.
- The stop sample is at E+HALF+(NUM_BITS+1)·CLKS_PER_BIT. `load_buffer` follows one cycle later. `data_ready` is visible the cycle after `load_buffer`.
- After a good frame, IDLE is re-entered the cycle after LOAD. A back-to-back start edge is accepted from that cycle.

## Configuration
- `RCV_CTRL_SYNC_EN` defined:
  - `serial_in` passes through an internal two-flop synchronizer, reset value 1, before the edge detector and every sample point.
  - All Timing figures shift by +2 cycles relative to the raw pin.
- Not defined: `serial_in` is used directly and must already be synchronous to `clk`.

## Test plan
All scenarios use CLKS_PER_BIT=10, NUM_BITS=8, no sync macro, and start edge at cycle E.
- Good frame, data 0xA5 sent LSB-first, stop=1 → 8 `shift_enable` pulses at E+15, E+25 … E+85; `load_buffer` at E+96; `data_ready`=1 from E+97; no error flags.
- Glitch: line low for 3 cycles then high → no `shift_enable`; back in IDLE at E+6; `rx_busy` high only for E+1..E+5.
- Stop bit 0 → `framing_error`=1 from E+96; no `load_buffer`; `data_ready` unchanged. The next good frame clears `framing_error` at its start sample.
- Two good frames with no `data_read` → `overrun_error`=1 after the second `load_buffer`. A following `data_read` pulse clears both `data_ready` and `overrun_error` the next cycle.
- `data_read` coincident with `load_buffer`, with `data_ready`=1 → `data_ready` stays 1, `overrun_error` stays 0.
- `rst` asserted at E+40 mid-RECV → all outputs 0 the next cycle; no `load_buffer`. A new frame started afterwards is received correctly.

Source files
------------

// File: rtl/rcv_ctrl_if.sv
// Line/host-side signal bundle for the 8N1 receive sequencer.
// slave: the sequencer itself; master: whoever drives the line and consumes the buffer.
interface rcv_ctrl_if;
    logic serial_in;
    logic data_read;
    logic shift_enable;
    logic load_buffer;
    logic data_ready;
    logic overrun_error;
    logic framing_error;
    logic rx_busy;

    modport master (
        output serial_in,
        output data_read,
        input  shift_enable,
        input  load_buffer,
        input  data_ready,
        input  overrun_error,
        input  framing_error,
        input  rx_busy
    );

    modport slave (
        input  serial_in,
        input  data_read,
        output shift_enable,
        output load_buffer,
        output data_ready,
        output overrun_error,
        output framing_error,
        output rx_busy
    );
endinterface

// File: rtl/rcv_ctrl.sv
// Receive-side sequencer for an 8N1 serial receiver: start detect, bit timing, stop check, status flags.
// Optional macro RCV_CTRL_SYNC_EN adds a two-flop synchronizer on serial_in (+2 cycles latency).
module rcv_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int NUM_BITS     = 8
) (
    input logic       clk,
    input logic       rst,
    rcv_ctrl_if.slave bus
);
    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W   = $clog2(NUM_BITS + 1);

    localparam logic [TIMER_W-1:0] HALF_M1  = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] BIT_END  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] TIMER_1  = TIMER_W'(1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(NUM_BITS - 1);
    localparam logic [CNT_W-1:0]   CNT_1    = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        RECV      = 3'd2,
        STOP_CHK  = 3'd3,
        LOAD      = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
    logic                 prev_in;
    logic                 line;
    logic                 data_ready, data_ready_n;
    logic                 overrun, overrun_n;
    logic                 framing, framing_n;
    logic                 shift_en;
    logic                 load;

`ifdef RCV_CTRL_SYNC_EN
    logic sync_p0, sync_p1;

    // Synchronizer stage boundary: pin -> sync_p0 -> sync_p1
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= bus.serial_in;
            sync_p1 <= sync_p0;
        end
    end

    assign line = sync_p1;
`else
    assign line = bus.serial_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            prev_in    <= 1'b1;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
            framing    <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            bit_cnt    <= bit_cnt_n;
            prev_in    <= line;
            data_ready <= data_ready_n;
            overrun    <= overrun_n;
            framing    <= framing_n;
        end
    end

    always_comb begin
        state_n      = state;
        timer_n      = timer;
        bit_cnt_n    = bit_cnt;
        framing_n    = framing;
        data_ready_n = data_ready;
        overrun_n    = overrun;
        shift_en     = 1'b0;
        load         = 1'b0;

        case (state)
            IDLE: begin
                // Only a fresh 1->0 edge starts a frame; a line held low never retriggers.
                if (prev_in && !line) begin
                    state_n = START_CHK;
                    timer_n = '0;
                end
            end
            START_CHK: begin
                timer_n = timer + TIMER_1;
                if (timer == HALF_M1) begin
                    timer_n = '0;
                    if (!line) begin
                        state_n   = RECV;
                        bit_cnt_n = '0;
                        framing_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            RECV: begin
                if (timer == BIT_END) begin
                    timer_n   = '0;
                    shift_en  = 1'b1;
                    bit_cnt_n = bit_cnt + CNT_1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = STOP_CHK;
                    end
                end else begin
                    timer_n = timer + TIMER_1;
                end
            end
            STOP_CHK: begin
                if (timer == BIT_END) begin
                    timer_n = '0;
                    if (line) begin
                        state_n = LOAD;
                    end else begin
                        framing_n = 1'b1;
                        state_n   = IDLE;
                    end
                end else begin
                    timer_n = timer + TIMER_1;
                end
            end
            LOAD: begin
                load    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase

        // A read coinciding with a load consumes the old byte, so no overrun is raised.
        if (load && data_ready && !bus.data_read) begin
            overrun_n = 1'b1;
        end else if (bus.data_read) begin
            overrun_n = 1'b0;
        end

        if (load) begin
            data_ready_n = 1'b1;
        end else if (bus.data_read) begin
            data_ready_n = 1'b0;
        end
    end

    assign bus.shift_enable  = shift_en;
    assign bus.load_buffer   = load;
    assign bus.rx_busy       = (state != IDLE);
    assign bus.data_ready    = data_ready;
    assign bus.overrun_error = overrun;
    assign bus.framing_error = framing;

endmodule

// File: tb/tb_rcv_ctrl.sv
// Randomized self-checking bench for rcv_ctrl against a frame-timing reference model.
module tb_rcv_ctrl;
    localparam int CPB    = 10;
    localparam int NB     = 8;
    localparam int HALF   = CPB / 2;
    localparam int T_STOP = HALF + (NB + 1) * CPB;
    localparam int T_LOAD = T_STOP + 1;

    logic clk = 1'b0;
    logic rst;

    rcv_ctrl_if bus ();

    rcv_ctrl #(.CLKS_PER_BIT(CPB), .NUM_BITS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    bit  m_ready = 1'b0;
    bit  m_ovr   = 1'b0;
    bit  m_frm   = 1'b0;

    // Line level at offset t from the start edge of a frame.
    function automatic logic frame_bit(input logic [7:0] d, input bit stop_ok,
                                       input int stop_hold, input int t);
        if (t < CPB) return 1'b0;
        if (t < (NB + 1) * CPB) return d[t / CPB - 1];
        if (t < (NB + 2) * CPB + stop_hold) return stop_ok;
        return 1'b1;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.serial_in = 1'b1;
            bus.data_read = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.serial_in = 1'b1;
        bus.data_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL reset rx_busy got=%b exp=0", bus.rx_busy); end
        if (bus.shift_enable !== 1'b0) begin errors++; $display("FAIL reset shift_enable got=%b exp=0", bus.shift_enable); end
        if (bus.load_buffer !== 1'b0) begin errors++; $display("FAIL reset load_buffer got=%b exp=0", bus.load_buffer); end
        if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL reset data_ready got=%b exp=0", bus.data_ready); end
        if (bus.overrun_error !== 1'b0) begin errors++; $display("FAIL reset overrun got=%b exp=0", bus.overrun_error); end
        if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL reset framing got=%b exp=0", bus.framing_error); end
        rst = 1'b0;
        m_ready = 1'b0; m_ovr = 1'b0; m_frm = 1'b0;
    endtask

    // One frame starting at the next cycle; read_off<0 means no data_read pulse.
    task automatic test_frame(input string name, input logic [7:0] data, input bit stop_ok,
                              input int read_off, input int stop_hold, input int tail);
        int         last;
        int         pulses;
        logic [7:0] got;
        logic       line;
        bit         exp_busy, exp_shift, exp_load, load_now, read_now;
        got    = '0;
        pulses = 0;
        last   = stop_ok ? (T_LOAD + tail) : ((NB + 2) * CPB + stop_hold + tail);
        for (int t = 0; t <= last; t++) begin
            @(posedge clk); #1;
            line      = frame_bit(data, stop_ok, stop_hold, t);
            exp_busy  = (t >= 1) && (t <= (stop_ok ? T_LOAD : T_STOP));
            exp_shift = (t >= HALF + CPB) && (t <= HALF + NB * CPB) && ((t - HALF) % CPB == 0);
            exp_load  = stop_ok && (t == T_LOAD);
            checks += 6;
            if (bus.rx_busy !== exp_busy) begin errors++;
                $display("FAIL %s rx_busy t=%0d got=%b exp=%b", name, t, bus.rx_busy, exp_busy); end
            if (bus.shift_enable !== exp_shift) begin errors++;
                $display("FAIL %s shift_enable t=%0d got=%b exp=%b", name, t, bus.shift_enable, exp_shift); end
            if (bus.load_buffer !== exp_load) begin errors++;
                $display("FAIL %s load_buffer t=%0d got=%b exp=%b", name, t, bus.load_buffer, exp_load); end
            if (bus.data_ready !== m_ready) begin errors++;
                $display("FAIL %s data_ready t=%0d got=%b exp=%b", name, t, bus.data_ready, m_ready); end
            if (bus.overrun_error !== m_ovr) begin errors++;
                $display("FAIL %s overrun t=%0d got=%b exp=%b", name, t, bus.overrun_error, m_ovr); end
            if (bus.framing_error !== m_frm) begin errors++;
                $display("FAIL %s framing t=%0d got=%b exp=%b", name, t, bus.framing_error, m_frm); end
            if (bus.shift_enable === 1'b1) begin
                got = {line, got[7:1]};
                pulses++;
            end
            bus.serial_in = line;
            bus.data_read = (t == read_off);
            read_now = (t == read_off);
            load_now = stop_ok && (t == T_LOAD);
            if (t == HALF) m_frm = 1'b0;
            if (!stop_ok && t == T_STOP) m_frm = 1'b1;
            if (load_now && m_ready && !read_now) m_ovr = 1'b1;
            else if (read_now) m_ovr = 1'b0;
            if (load_now) m_ready = 1'b1;
            else if (read_now) m_ready = 1'b0;
        end
        @(posedge clk); #1;
        bus.data_read = 1'b0;
        bus.serial_in = 1'b1;
        checks += 1;
        if (pulses != NB) begin errors++;
            $display("FAIL %s pulse_count got=%0d exp=%0d", name, pulses, NB); end
        if (stop_ok) begin
            checks += 1;
            if (got !== data) begin errors++;
                $display("FAIL %s shifted_byte got=%h exp=%h", name, got, data); end
        end
    endtask

    task automatic test_data_read(input string name);
        @(posedge clk); #1;
        checks += 2;
        if (bus.data_ready !== m_ready) begin errors++;
            $display("FAIL %s pre data_ready got=%b exp=%b", name, bus.data_ready, m_ready); end
        if (bus.overrun_error !== m_ovr) begin errors++;
            $display("FAIL %s pre overrun got=%b exp=%b", name, bus.overrun_error, m_ovr); end
        bus.data_read = 1'b1;
        @(posedge clk); #1;
        bus.data_read = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        checks += 2;
        if (bus.data_ready !== 1'b0) begin errors++;
            $display("FAIL %s data_ready got=%b exp=0", name, bus.data_ready); end
        if (bus.overrun_error !== 1'b0) begin errors++;
            $display("FAIL %s overrun got=%b exp=0", name, bus.overrun_error); end
    endtask

    task automatic test_glitch();
        int  len;
        bit  exp_busy;
        len = $urandom_range(1, HALF);
        for (int t = 0; t < 16; t++) begin
            @(posedge clk); #1;
            exp_busy = (t >= 1) && (t <= HALF);
            checks += 4;
            if (bus.rx_busy !== exp_busy) begin errors++;
                $display("FAIL glitch rx_busy t=%0d len=%0d got=%b exp=%b", t, len, bus.rx_busy, exp_busy); end
            if (bus.shift_enable !== 1'b0) begin errors++;
                $display("FAIL glitch shift_enable t=%0d got=%b exp=0", t, bus.shift_enable); end
            if (bus.load_buffer !== 1'b0) begin errors++;
                $display("FAIL glitch load_buffer t=%0d got=%b exp=0", t, bus.load_buffer); end
            if (bus.framing_error !== m_frm) begin errors++;
                $display("FAIL glitch framing t=%0d got=%b exp=%b", t, bus.framing_error, m_frm); end
            bus.serial_in = (t < len) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'($urandom);
        for (int t = 0; t <= 40; t++) begin
            @(posedge clk); #1;
            bus.serial_in = frame_bit(d, 1'b1, 0, t);
            if (t == 40) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.serial_in = 1'b1;
        checks += 6;
        if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL mid_rst rx_busy got=%b exp=0", bus.rx_busy); end
        if (bus.shift_enable !== 1'b0) begin errors++; $display("FAIL mid_rst shift_enable got=%b exp=0", bus.shift_enable); end
        if (bus.load_buffer !== 1'b0) begin errors++; $display("FAIL mid_rst load_buffer got=%b exp=0", bus.load_buffer); end
        if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL mid_rst data_ready got=%b exp=0", bus.data_ready); end
        if (bus.overrun_error !== 1'b0) begin errors++; $display("FAIL mid_rst overrun got=%b exp=0", bus.overrun_error); end
        if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL mid_rst framing got=%b exp=0", bus.framing_error); end
        m_ready = 1'b0; m_ovr = 1'b0; m_frm = 1'b0;
        for (int t = 0; t < 80; t++) begin
            @(posedge clk); #1;
            checks += 2;
            if (bus.rx_busy !== 1'b0) begin errors++;
                $display("FAIL mid_rst quiet rx_busy t=%0d got=%b exp=0", t, bus.rx_busy); end
            if (bus.load_buffer !== 1'b0) begin errors++;
                $display("FAIL mid_rst quiet load_buffer t=%0d got=%b exp=0", t, bus.load_buffer); end
        end
        test_frame("post_rst", 8'($urandom), 1'b1, -1, 0, 2);
    endtask

    task automatic test_random_frames(input int n);
        bit  stop_ok;
        int  r, rd, tail;
        for (int i = 0; i < n; i++) begin
            stop_ok = ($urandom_range(0, 3) != 0);
            r    = $urandom_range(0, 3);
            tail = $urandom_range(0, 4);
            case (r)
                0:       rd = -1;
                1:       rd = T_LOAD;
                2:       rd = $urandom_range(0, T_LOAD - 1);
                default: rd = T_LOAD + 1 + $urandom_range(0, 4);
            endcase
            test_frame("random", 8'($urandom), stop_ok, rd, $urandom_range(0, 12), tail);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.serial_in = 1'b1;
        bus.data_read = 1'b0;
        test_reset();
        idle_cycles(3);
        test_frame("good_a5", 8'hA5, 1'b1, -1, 0, 3);
        test_data_read("read_after_good");
        idle_cycles(2);
        test_glitch();
        idle_cycles(2);
        test_frame("framing", 8'($urandom), 1'b0, -1, $urandom_range(5, 20), 4);
        test_frame("clear_framing", 8'($urandom), 1'b1, -1, 0, 2);
        test_data_read("read_before_overrun");
        test_frame("overrun_1", 8'($urandom), 1'b1, -1, 0, 0);
        test_frame("overrun_2", 8'($urandom), 1'b1, -1, 0, 1);
        test_data_read("read_clears_overrun");
        test_frame("ready_again", 8'($urandom), 1'b1, -1, 0, 1);
        test_frame("read_coincident", 8'($urandom), 1'b1, T_LOAD, 0, 2);
        test_reset_mid_frame();
        test_random_frames(8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
